// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are added CHUNK bits per clock,
// LSB slice first, with a start/done handshake, subtract mode and signed overflow.
module chunked_seq_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   s_sl;
  logic             ovf_sl;

  always_comb begin
    a_sl   = a_r[idx*CHUNK +: CHUNK];
    b_sl   = b_r[idx*CHUNK +: CHUNK];
    s_sl   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    // Same-sign operands giving an opposite-sign MSB is exactly carry-in(MSB) ^ carry-out(MSB).
    ovf_sl = (a_sl[CHUNK-1] == b_sl[CHUNK-1]) && (s_sl[CHUNK-1] != a_sl[CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        // The done cycle also accepts a new start, giving one op every N+1 cycles.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= s_sl[CHUNK-1:0];
          carry <= s_sl[CHUNK];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout     <= s_sl[CHUNK];
            overflow <= ovf_sl;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
